enc_top: RTL and testbench
==========================

# enc_top

Dual-channel incremental-encoder pulse counter for the DAQ front end. Each channel counts rising edges of its A input while the block is armed, and on each rising edge of its Z (index) input latches the count onto its output, pulses a ready strobe and restarts counting. Synchronized copies of the raw encoder and select inputs are forwarded for monitoring and routing. An AXI wrapper reads the latched counts and the ready/overflow flags.

## Interface
- CNT_WIDTH, 16: width of each channel counter and of O_CNT_A0/O_CNT_A1.
- CLK  in  1  single system clock (nominal 128 MHz); all logic on its rising edge.
- RST  in  1  reset; asynchronous and active-high. Clears every register.
- I_ARM  in  1  async; measurement enable for both channels.
- I_SEL  in  1  async; channel-select level, forwarded only.
- I_A0, I_A1  in  1  async; encoder pulse inputs, channels 0/1.
- I_Z0, I_Z1  in  1  async; index pulse inputs, channels 0/1.
- O_A0, O_A1, O_Z0, O_Z1  out  1  synchronized copies of I_A0/I_A1/I_Z0/I_Z1.
- O_SEL  out  1  synchronized copy of I_SEL.
- O_CNT_A0, O_CNT_A1  out  CNT_WIDTH  last latched count per channel.
- O_OVERFLOW_0, O_OVERFLOW_1  out  1  saturation flag belonging to the latched count.
- O_READY_0, O_READY_1  out  1  one-cycle strobe when a new count is latched.

## Operation
- Every async input (I_ARM, I_SEL, I_Ax, I_Zx) passes through a 2-flop synchronizer (s1, s2). A third flop holds the previous s2 value for edge detection.
- A rising edge is asserted when s2 = 1 and prev = 0. It lasts exactly one cycle per input pulse, whatever the pulse width (≥ 1 CLK period).
- O_Ax, O_Zx and O_SEL are driven from s2.
- Armed = s2 of I_ARM. Each channel x is independent and identical:
  - Armed, A edge: counter increments. At all-ones it holds (saturates) and sets an internal ovf_pending bit.
  - Armed, Z edge: O_CNT_Ax ← counter + (1 if an A edge occurs in the same cycle, saturating). O_OVERFLOW_x ← ovf_pending OR (saturation in this cycle). O_READY_x = 1 for that cycle. Counter ← 0 and ovf_pending ← 0.
  - Not armed: counter and ovf_pending forced to 0. Edges are ignored. O_CNT_Ax and O_OVERFLOW_x hold their last values, and O_READY_x stays 0.
  - Arm rising: counting starts from 0. An A edge in the first armed cycle is counted.
- Z edge with counter = 0 latches 0 and still strobes ready.
- Channels never interact. Simultaneous events on both channels are handled independently in the same cycle.

## Timing
- Input first sampled high at CLK edge k:
  - s1 is set at k and s2 at k+1, so O_Ax/O_Zx/O_SEL go high after edge k+1.
  - The edge pulse is active during the cycle after k+1.
  - Counter and latched outputs update at edge k+2.
- O_READY_x goes high after edge k+2 and low after edge k+3.
- Arm latency: the same 2-cycle synchronization. Disarm clears the counter at edge k+2.
- Reset: asserting RST immediately, asynchronously, clears every output, counter, synchronizer and ovf_pending bit to 0. After release, a level already high on an input produces a rising edge (prev = 0).
- Reset mid-period discards the count in progress.
- Max counted rate: one A edge per 2 CLK cycles (high ≥ 1 cycle, low ≥ 1 cycle).

## Test plan
- Reset, then idle: every output is 0.
- Arm, 3 A0 pulses, then a Z0 pulse 1 cycle after the 3rd A0: O_CNT_A0 = 3, O_READY_0 is a single 1-cycle pulse, O_OVERFLOW_0 = 0. The same sequence on channel 1 runs concurrently with independent results.
- Armed, random 3–30-cycle gaps between A pulses, Z every 3 A pulses, for 50 periods: every latch = 3. O_A/O_Z follow the inputs with a 2-cycle delay.
- Disarmed: 10 A0 pulses and a Z0 pulse produce no ready and leave O_CNT_A0 unchanged. Re-arm, 2 A0 pulses, Z0: O_CNT_A0 = 2.
- Armed, 65540 A0 pulses with no Z0, then Z0: O_CNT_A0 = 16'hFFFF and O_OVERFLOW_0 = 1. Next period: 3 A0 pulses, Z0, giving O_CNT_A0 = 3 and O_OVERFLOW_0 = 0.
- A0 and Z0 rising in the same CLK cycle after 4 prior A0 pulses: O_CNT_A0 = 5 and the next count starts at 0.
- RST asserted mid-count (after 2 A0 pulses): all outputs are 0 immediately. Then 3 A0 pulses and Z0 give O_CNT_A0 = 3.

Source files
------------

// File: rtl/enc_top.sv
// Dual-channel encoder pulse counter: synchronizes raw encoder inputs, counts A edges
// per channel while armed and latches the count on each Z (index) edge.
module enc_top #(
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 I_ARM,
  input  logic                 I_SEL,
  input  logic                 I_A0,
  input  logic                 I_A1,
  input  logic                 I_Z0,
  input  logic                 I_Z1,
  output logic                 O_A0,
  output logic                 O_A1,
  output logic                 O_Z0,
  output logic                 O_Z1,
  output logic                 O_SEL,
  output logic [CNT_WIDTH-1:0] O_CNT_A0,
  output logic [CNT_WIDTH-1:0] O_CNT_A1,
  output logic                 O_OVERFLOW_0,
  output logic                 O_OVERFLOW_1,
  output logic                 O_READY_0,
  output logic                 O_READY_1
);

  localparam int unsigned IdxArm = 0;
  localparam int unsigned IdxSel = 1;
  localparam int unsigned IdxA0  = 2;
  localparam int unsigned IdxA1  = 3;
  localparam int unsigned IdxZ0  = 4;
  localparam int unsigned IdxZ1  = 5;

  logic [5:0] w_async;
  logic [5:0] r_s1;
  logic [5:0] r_s2;
  logic [5:0] r_prev;
  logic [5:0] w_rise;
  logic       w_armed;
  logic [1:0] w_a_edge;
  logic [1:0] w_z_edge;

  assign w_async = {I_Z1, I_Z0, I_A1, I_A0, I_SEL, I_ARM};

  // Two-flop synchronizer plus a history flop for rising-edge detection.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_s1   <= '0;
      r_s2   <= '0;
      r_prev <= '0;
    end else begin
      r_s1   <= w_async;
      r_s2   <= r_s1;
      r_prev <= r_s2;
    end
  end

  assign w_rise   = r_s2 & ~r_prev;
  assign w_armed  = r_s2[IdxArm];
  assign w_a_edge = {w_rise[IdxA1], w_rise[IdxA0]};
  assign w_z_edge = {w_rise[IdxZ1], w_rise[IdxZ0]};

  assign O_A0  = r_s2[IdxA0];
  assign O_A1  = r_s2[IdxA1];
  assign O_Z0  = r_s2[IdxZ0];
  assign O_Z1  = r_s2[IdxZ1];
  assign O_SEL = r_s2[IdxSel];

  for (genvar g = 0; g < 2; g++) begin : g_ch
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [CNT_WIDTH-1:0] r_lat;
    logic                 r_ovf_pend;
    logic                 r_ovf;
    logic                 r_ready;
    logic                 w_sat;
    logic                 w_sat_hit;
    logic [CNT_WIDTH-1:0] w_next;

    assign w_sat     = &r_cnt;
    assign w_sat_hit = w_a_edge[g] & w_sat;
    assign w_next    = (w_a_edge[g] && !w_sat) ? r_cnt + CNT_WIDTH'(1) : r_cnt;

    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        r_cnt      <= '0;
        r_lat      <= '0;
        r_ovf_pend <= 1'b0;
        r_ovf      <= 1'b0;
        r_ready    <= 1'b0;
      end else if (!w_armed) begin
        r_cnt      <= '0;
        r_ovf_pend <= 1'b0;
        r_ready    <= 1'b0;
      end else if (w_z_edge[g]) begin
        // An A edge coinciding with the index is folded into the latched count.
        r_lat      <= w_next;
        r_ovf      <= r_ovf_pend | w_sat_hit;
        r_ready    <= 1'b1;
        r_cnt      <= '0;
        r_ovf_pend <= 1'b0;
      end else begin
        r_cnt      <= w_next;
        r_ovf_pend <= r_ovf_pend | w_sat_hit;
        r_ready    <= 1'b0;
      end
    end
  end

  assign O_CNT_A0     = g_ch[0].r_lat;
  assign O_CNT_A1     = g_ch[1].r_lat;
  assign O_OVERFLOW_0 = g_ch[0].r_ovf;
  assign O_OVERFLOW_1 = g_ch[1].r_ovf;
  assign O_READY_0    = g_ch[0].r_ready;
  assign O_READY_1    = g_ch[1].r_ready;

endmodule

// File: tb/tb_enc_top.sv
// Directed bench for enc_top: latch values, ready strobes, arming, saturation and reset.
module tb_enc_top;

  localparam int unsigned CntW = 8;

  logic            CLK = 1'b0;
  logic            RST = 1'b1;
  logic            I_ARM = 1'b0;
  logic            I_SEL = 1'b0;
  logic            I_A0 = 1'b0;
  logic            I_A1 = 1'b0;
  logic            I_Z0 = 1'b0;
  logic            I_Z1 = 1'b0;
  logic            O_A0, O_A1, O_Z0, O_Z1, O_SEL;
  logic [CntW-1:0] O_CNT_A0, O_CNT_A1;
  logic            O_OVERFLOW_0, O_OVERFLOW_1, O_READY_0, O_READY_1;

  enc_top #(.CNT_WIDTH(CntW)) u_dut (
    .CLK          (CLK),
    .RST          (RST),
    .I_ARM        (I_ARM),
    .I_SEL        (I_SEL),
    .I_A0         (I_A0),
    .I_A1         (I_A1),
    .I_Z0         (I_Z0),
    .I_Z1         (I_Z1),
    .O_A0         (O_A0),
    .O_A1         (O_A1),
    .O_Z0         (O_Z0),
    .O_Z1         (O_Z1),
    .O_SEL        (O_SEL),
    .O_CNT_A0     (O_CNT_A0),
    .O_CNT_A1     (O_CNT_A1),
    .O_OVERFLOW_0 (O_OVERFLOW_0),
    .O_OVERFLOW_1 (O_OVERFLOW_1),
    .O_READY_0    (O_READY_0),
    .O_READY_1    (O_READY_1)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  int   rdy_rise0 = 0, rdy_hi0 = 0, rdy_rise1 = 0, rdy_hi1 = 0;
  logic prev_r0 = 1'b0, prev_r1 = 1'b0;
  logic follow_en = 1'b0;
  int   follow_err = 0;
  logic h_a0 = 1'b0, h_z0 = 1'b0, h_sel = 1'b0;

  // Observes outputs at the falling edge, before the driver updates inputs (#1 later).
  always @(negedge CLK) begin
    if (O_READY_0) rdy_hi0++;
    if (O_READY_0 && !prev_r0) rdy_rise0++;
    if (O_READY_1) rdy_hi1++;
    if (O_READY_1 && !prev_r1) rdy_rise1++;
    prev_r0 = O_READY_0;
    prev_r1 = O_READY_1;
    if (follow_en) begin
      if (O_A0 !== h_a0) follow_err++;
      if (O_Z0 !== h_z0) follow_err++;
      if (O_SEL !== h_sel) follow_err++;
    end
    h_a0  = I_A0;
    h_z0  = I_Z0;
    h_sel = I_SEL;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic a0, input logic a1, input logic z0, input logic z1);
    @(negedge CLK);
    #1;
    I_A0 = a0;
    I_A1 = a1;
    I_Z0 = z0;
    I_Z1 = z1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pulses(input int n0, input int n1);
    int n;
    n = (n0 > n1) ? n0 : n1;
    for (int i = 0; i < n; i++) begin
      cyc(i < n0, i < n1, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic index(input logic z0, input logic z1);
    cyc(1'b0, 1'b0, z0, z1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    idle(4);
  endtask

  task automatic set_arm(input logic v);
    @(negedge CLK);
    #1;
    I_ARM = v;
    idle(3);
  endtask

  // Checks channel 0 latch/overflow and that exactly rdy strobes of one cycle occurred.
  task automatic check_ch0(input string tag, input int r0, input int h0,
                           input logic [31:0] exp_cnt, input logic exp_ovf, input int exp_rdy);
    check({tag, "_cnt0"}, 32'(O_CNT_A0), exp_cnt);
    check({tag, "_ovf0"}, 32'(O_OVERFLOW_0), 32'(exp_ovf));
    check({tag, "_rdy0"}, 32'(rdy_rise0 - r0), 32'(exp_rdy));
    check({tag, "_rdyw0"}, 32'(rdy_hi0 - h0), 32'(exp_rdy));
  endtask

  task automatic check_ch1(input string tag, input int r1, input int h1,
                           input logic [31:0] exp_cnt, input logic exp_ovf, input int exp_rdy);
    check({tag, "_cnt1"}, 32'(O_CNT_A1), exp_cnt);
    check({tag, "_ovf1"}, 32'(O_OVERFLOW_1), 32'(exp_ovf));
    check({tag, "_rdy1"}, 32'(rdy_rise1 - r1), 32'(exp_rdy));
    check({tag, "_rdyw1"}, 32'(rdy_hi1 - h1), 32'(exp_rdy));
  endtask

  initial begin
    int r0, h0, r1, h1;
    logic [8:0] outs;

    // Reset and idle
    repeat (3) @(negedge CLK);
    #1 RST = 1'b0;
    idle(4);
    outs = {O_A0, O_A1, O_Z0, O_Z1, O_SEL, O_OVERFLOW_0, O_OVERFLOW_1, O_READY_0, O_READY_1};
    check("reset_flags", 32'(outs), 32'd0);
    check("reset_cnt0", 32'(O_CNT_A0), 32'd0);
    check("reset_cnt1", 32'(O_CNT_A1), 32'd0);

    // Basic: 3 pulses on both channels, index one cycle after the last pulse
    set_arm(1'b1);
    r0 = rdy_rise0; h0 = rdy_hi0; r1 = rdy_rise1; h1 = rdy_hi1;
    pulses(3, 3);
    index(1'b1, 1'b1);
    check_ch0("basic", r0, h0, 32'd3, 1'b0, 1);
    check_ch1("basic", r1, h1, 32'd3, 1'b0, 1);

    // Index with an empty counter still strobes and latches zero
    r0 = rdy_rise0; h0 = rdy_hi0; r1 = rdy_rise1; h1 = rdy_hi1;
    index(1'b1, 1'b0);
    check_ch0("zero", r0, h0, 32'd0, 1'b0, 1);
    check_ch1("zero", r1, h1, 32'd3, 1'b0, 0);

    // Random gaps, index every 3 pulses; synchronized copies follow with 2-cycle lag
    follow_en = 1'b1;
    for (int p = 0; p < 50; p++) begin
      r0 = rdy_rise0; h0 = rdy_hi0;
      @(negedge CLK);
      #1 I_SEL = 1'($urandom_range(0, 1));
      for (int k = 0; k < 3; k++) begin
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        idle(int'($urandom_range(3, 30)));
      end
      index(1'b1, 1'b0);
      check_ch0("rand", r0, h0, 32'd3, 1'b0, 1);
    end
    follow_en = 1'b0;
    check("follow", 32'(follow_err), 32'd0);

    // Disarmed: edges ignored, latched value held
    set_arm(1'b0);
    r0 = rdy_rise0; h0 = rdy_hi0;
    pulses(10, 0);
    index(1'b1, 1'b0);
    check_ch0("disarm", r0, h0, 32'd3, 1'b0, 0);
    set_arm(1'b1);
    r0 = rdy_rise0; h0 = rdy_hi0;
    pulses(2, 0);
    index(1'b1, 1'b0);
    check_ch0("rearm", r0, h0, 32'd2, 1'b0, 1);

    // Saturation on channel 0 while channel 1 counts one pulse
    r0 = rdy_rise0; h0 = rdy_hi0; r1 = rdy_rise1; h1 = rdy_hi1;
    pulses(260, 1);
    index(1'b1, 1'b1);
    check_ch0("sat", r0, h0, 32'hFF, 1'b1, 1);
    check_ch1("sat", r1, h1, 32'd1, 1'b0, 1);
    r0 = rdy_rise0; h0 = rdy_hi0;
    pulses(3, 0);
    index(1'b1, 1'b0);
    check_ch0("post_sat", r0, h0, 32'd3, 1'b0, 1);

    // A and Z in the same cycle after 4 pulses
    r0 = rdy_rise0; h0 = rdy_hi0;
    pulses(4, 0);
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    idle(4);
    check_ch0("same_cyc", r0, h0, 32'd5, 1'b0, 1);
    r0 = rdy_rise0; h0 = rdy_hi0;
    pulses(2, 0);
    index(1'b1, 1'b0);
    check_ch0("restart", r0, h0, 32'd2, 1'b0, 1);

    // Reset in the middle of a period
    pulses(2, 0);
    @(negedge CLK);
    #1 RST = 1'b1;
    #1;
    outs = {O_A0, O_A1, O_Z0, O_Z1, O_SEL, O_OVERFLOW_0, O_OVERFLOW_1, O_READY_0, O_READY_1};
    check("rst_mid_flags", 32'(outs), 32'd0);
    check("rst_mid_cnt0", 32'(O_CNT_A0), 32'd0);
    check("rst_mid_cnt1", 32'(O_CNT_A1), 32'd0);
    @(negedge CLK);
    #1 RST = 1'b0;
    idle(3);
    r0 = rdy_rise0; h0 = rdy_hi0;
    pulses(3, 0);
    index(1'b1, 1'b0);
    check_ch0("after_rst", r0, h0, 32'd3, 1'b0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
